// File: rtl/usb_in_ep_fifo.sv
// ---------------------------------------------------------------------------
// usb_in_ep_fifo
//
// Byte FIFO on the endpoint side of the USB protocol engine's IN interface.
// User logic pushes bytes with a valid/ready handshake. The block cuts them
// into IN packets of up to MAX_PKT bytes, requests the IN data bus, streams
// the bytes to the engine and marks each packet complete. Space is given back
// only when the engine reports the packet as ACKed, so a packet that is
// retried by the engine never loses its data.
//
// Parameters:
//   DEPTH   - FIFO size in bytes (power of two, >= MAX_PKT)
//   MAX_PKT - largest IN payload in bytes (1..64)
//
// Ports:
//   clk, reset       - single clock, synchronous active-high reset
//   wr_data/valid    - user byte and its valid strobe
//   wr_ready         - FIFO can take a byte
//   flush            - pulse: send buffered bytes even if short of MAX_PKT
//   stall            - user request to STALL the endpoint
//   in_ep_req        - request for the IN data bus
//   in_ep_grant      - bus granted by the arbiter
//   in_ep_data_free  - engine buffer can take a byte
//   in_ep_data_put   - byte strobe into the engine
//   in_ep_data       - byte to the engine
//   in_ep_data_done  - one-cycle pulse, packet fully loaded
//   in_ep_stall      - registered copy of stall
//   in_ep_acked      - pulse, host ACKed the last packet
//   busy             - FSM is not idle
//
// Build option:
//   USB_IN_EP_ZLP_EN - when defined, a flush that ends on an exactly
//                      MAX_PKT-sized packet is followed by a zero-length
//                      packet so the host sees the end of the transfer.
// ---------------------------------------------------------------------------
module usb_in_ep_fifo #(
    parameter int DEPTH   = 64,
    parameter int MAX_PKT = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] wr_data,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic       flush,
    input  logic       stall,
    output logic       in_ep_req,
    input  logic       in_ep_grant,
    input  logic       in_ep_data_free,
    output logic       in_ep_data_put,
    output logic [7:0] in_ep_data,
    output logic       in_ep_data_done,
    output logic       in_ep_stall,
    input  logic       in_ep_acked,
    output logic       busy
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam logic [PW-1:0] DEPTH_W   = PW'(DEPTH);
    localparam logic [PW-1:0] MAX_PKT_W = PW'(MAX_PKT);

    typedef enum logic [1:0] {IDLE, REQ, XFER, WAIT_ACK} state_t;

    state_t        state;
    logic [7:0]    mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] spec_ptr;
    logic [PW-1:0] commit_ptr;
    logic [PW-1:0] pkt_len;
    logic [PW-1:0] sent;
    logic          flush_pending;
`ifdef USB_IN_EP_ZLP_EN
    logic          zlp_pending;
`endif

    logic [PW-1:0] occupancy;
    logic [PW-1:0] launch_len;
    logic          launch_data;
    logic          last_chunk;
    logic          wr_en;
    logic          put_ok;

    // Occupancy counts against the ACKed pointer, so bytes already sent but
    // not yet acknowledged still hold their space.
    assign occupancy   = wr_ptr - commit_ptr;
    assign wr_ready    = occupancy < DEPTH_W;
    assign wr_en       = wr_valid && wr_ready;

    assign launch_data = (occupancy >= MAX_PKT_W) || (flush_pending && (occupancy != '0));
    assign launch_len  = (occupancy >= MAX_PKT_W) ? MAX_PKT_W : occupancy;
    assign last_chunk  = (launch_len == occupancy);

    // Puts follow grant and free combinationally so back-pressure pauses the
    // stream in the same cycle without dropping or repeating a byte.
    assign put_ok          = (state == XFER) && in_ep_grant && in_ep_data_free && (sent != pkt_len);
    assign in_ep_data_put  = put_ok;
    assign in_ep_data      = mem[spec_ptr[AW-1:0]];
    assign in_ep_data_done = (state == XFER) && (sent == pkt_len);
    assign in_ep_req       = (state == REQ) || (state == XFER);
    assign busy            = (state != IDLE);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            spec_ptr      <= '0;
            commit_ptr    <= '0;
            pkt_len       <= '0;
            sent          <= '0;
            flush_pending <= 1'b0;
`ifdef USB_IN_EP_ZLP_EN
            zlp_pending   <= 1'b0;
`endif
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (launch_data) begin
                        pkt_len <= launch_len;
                        sent    <= '0;
                        if (last_chunk) begin
                            flush_pending <= 1'b0;
                        end
`ifdef USB_IN_EP_ZLP_EN
                        // A flush ending on a full-size packet needs a ZLP
                        // terminator; any other launch cancels a stale one.
                        zlp_pending <= flush_pending && last_chunk && (launch_len == MAX_PKT_W);
`endif
                        state <= REQ;
                    end
`ifdef USB_IN_EP_ZLP_EN
                    else if (zlp_pending && (occupancy == '0)) begin
                        pkt_len     <= '0;
                        sent        <= '0;
                        zlp_pending <= 1'b0;
                        state       <= REQ;
                    end
`endif
                end
                REQ: begin
                    if (in_ep_grant) begin
                        state <= XFER;
                    end
                end
                XFER: begin
                    if (put_ok) begin
                        spec_ptr <= spec_ptr + 1'b1;
                        sent     <= sent + 1'b1;
                    end else if (sent == pkt_len) begin
                        state <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (in_ep_acked) begin
                        commit_ptr <= spec_ptr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            // A flush seen in any state, even during a launch, stays pending
            // for the next launch decision.
            if (flush) begin
                flush_pending <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            in_ep_stall <= 1'b0;
        end else begin
            in_ep_stall <= stall;
        end
    end

endmodule
